// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage with IF/ID register and one-entry skid buffer.
// Single outstanding request on a req/gnt/rvalid instruction-memory port.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallPC,
    input  logic        StallF,
    input  logic        FlushF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_KILL
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pcf;
    logic [31:0] pcf_nx;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        live;
    logic        consume;
    logic        issue;
    logic        hs;

    always_comb begin
        live     = (state == S_WAIT) && imem_rvalid_i;
        consume  = live && !StallF && !FlushF;
        issue    = rst_n && !StallPC && !PCSrcE && !skid_valid
                   && ((state == S_REQ) || consume);
        hs       = issue && imem_gnt_i;
        state_nx = state;
        pcf_nx   = pcf;
        if (PCSrcE) begin
            pcf_nx = {PCTargetE[31:2], 2'b00};
            // An outstanding request that returns this very cycle is done.
            if ((state != S_REQ) && !imem_rvalid_i) begin
                state_nx = S_KILL;
            end else begin
                state_nx = S_REQ;
            end
        end else if (hs) begin
            state_nx = S_WAIT;
            pcf_nx   = pcf + 32'd4;
        end else if ((state != S_REQ) && imem_rvalid_i) begin
            state_nx = S_REQ;
        end
    end

    assign imem_req_o  = issue;
    assign imem_addr_o = pcf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            pcf    <= RESET_PC;
            req_pc <= 32'h0;
        end else begin
            state <= state_nx;
            pcf   <= pcf_nx;
            if (hs) begin
                req_pc <= pcf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
        end else if (PCSrcE || FlushF) begin
            skid_valid <= 1'b0;
        end else if (live && StallF) begin
            skid_valid <= 1'b1;
            skid_instr <= imem_rdata_i;
            skid_pc    <= req_pc;
        end else if (!StallF) begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
        end else if (FlushF) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
        end else if (!StallF) begin
            if (skid_valid) begin
                ValidD   <= 1'b1;
                InstrD   <= skid_instr;
                PCD      <= skid_pc;
                PCPlus4D <= skid_pc + 32'd4;
            end else if (live) begin
                ValidD   <= 1'b1;
                InstrD   <= imem_rdata_i;
                PCD      <= req_pc;
                PCPlus4D <= req_pc + 32'd4;
            end else begin
                ValidD   <= 1'b0;
                InstrD   <= NOP_INSTR;
                PCD      <= 32'h0;
                PCPlus4D <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a programmable-latency memory responder.
// Inputs change just after posedge; combinational outputs are sampled after negedge.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        StallPC;
    logic        StallF;
    logic        FlushF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int failures = 0;
    int gnt_dly = 0;
    int rlat = 1;
    int gwait = 0;
    logic [31:0] q_addr[$];
    int          q_cnt[$];

    fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .StallPC(StallPC),
        .StallF(StallF),
        .FlushF(FlushF),
        .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE),
        .imem_req_o(req),
        .imem_addr_o(addr),
        .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata),
        .InstrD(InstrD),
        .PCD(PCD),
        .PCPlus4D(PCPlus4D),
        .ValidD(ValidD)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #2;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: rvalid driven at negedge, grant decided 1 time unit later.
    initial begin
        gnt = 1'b0;
        rvalid = 1'b0;
        rdata = 32'h0;
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            if (q_cnt.size() > 0 && q_cnt[0] == 0) begin
                rvalid = 1'b1;
                rdata = mem_word(q_addr[0]);
                q_addr.delete(0);
                q_cnt.delete(0);
            end
            foreach (q_cnt[i]) q_cnt[i] = q_cnt[i] - 1;
            #1;
            gnt = 1'b0;
            if (req) begin
                if (gwait >= gnt_dly) begin
                    gnt = 1'b1;
                    gwait = 0;
                    q_addr.push_back(addr);
                    q_cnt.push_back(rlat - 1);
                end else begin
                    gwait++;
                end
            end else begin
                gwait = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        StallPC = 1'b0;
        StallF = 1'b0;
        FlushF = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = 32'h0;

        repeat (2) cyc();
        check("rst_valid", ValidD, 1'b0);
        check("rst_instr", InstrD, 32'h0000_0013);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pc4", PCPlus4D, 32'h0);
        mid();
        check("rst_req", req, 1'b0);
        check("rst_addr", addr, 32'h0);
        cyc();
        rst_n = 1'b1;

        // Zero-wait streaming
        mid();
        check("s_req0", req, 1'b1);
        check("s_addr0", addr, 32'h0);
        cyc();
        check("s_valid_lat", ValidD, 1'b0);
        mid();
        check("s_addr1", addr, 32'h4);
        cyc();
        check("s_valid0", ValidD, 1'b1);
        check("s_pcd0", PCD, 32'h0);
        check("s_instr0", InstrD, mem_word(32'h0));
        check("s_pc4_0", PCPlus4D, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check("s_pcd", PCD, 32'(4 * k));
            check("s_pc4", PCPlus4D, 32'(4 * k + 4));
            check("s_instr", InstrD, mem_word(32'(4 * k)));
        end

        // Stall: response for 0x10 goes to the skid buffer
        StallF = 1'b1;
        StallPC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("st_req", req, 1'b0);
            cyc();
            check("st_pcd_hold", PCD, 32'hC);
            check("st_valid_hold", ValidD, 1'b1);
        end
        StallF = 1'b0;
        StallPC = 1'b0;
        mid();
        check("st_req_skid", req, 1'b0);
        cyc();
        check("st_skid_pcd", PCD, 32'h10);
        check("st_skid_instr", InstrD, mem_word(32'h10));
        mid();
        check("st_resume_req", req, 1'b1);
        check("st_resume_addr", addr, 32'h14);
        cyc();
        check("st_bubble", ValidD, 1'b0);
        rlat = 3;
        cyc();
        check("st_pcd_next", PCD, 32'h14);
        check("st_instr_next", InstrD, mem_word(32'h14));

        // Redirect with a request to 0x18 outstanding
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0103;
        FlushF = 1'b1;
        mid();
        check("rd_req_sup", req, 1'b0);
        cyc();
        check("rd_flush_valid", ValidD, 1'b0);
        check("rd_flush_instr", InstrD, 32'h0000_0013);
        check("rd_flush_pcd", PCD, 32'h0);
        PCSrcE = 1'b0;
        FlushF = 1'b0;
        mid();
        check("rd_kill_req0", req, 1'b0);
        cyc();
        mid();
        check("rd_kill_req1", req, 1'b0);
        cyc();
        check("rd_dropped", ValidD, 1'b0);
        mid();
        check("rd_req", req, 1'b1);
        check("rd_addr", addr, 32'h0000_0100);
        repeat (4) cyc();
        check("rd_pcd", PCD, 32'h0000_0100);
        check("rd_instr", InstrD, mem_word(32'h100));

        // Slow grant and slow response
        gnt_dly = 4;
        repeat (2) cyc();
        for (int i = 0; i < 5; i++) begin
            mid();
            check("sg_req", req, 1'b1);
            check("sg_addr", addr, 32'h108);
            cyc();
        end
        check("sg_bubble", ValidD, 1'b0);
        mid();
        check("sg_single0", req, 1'b0);
        cyc();
        mid();
        check("sg_single1", req, 1'b0);
        cyc();
        check("sg_wait_valid", ValidD, 1'b0);
        mid();
        check("sg_next_addr", addr, 32'h10C);
        cyc();
        check("sg_pcd", PCD, 32'h108);
        check("sg_instr", InstrD, mem_word(32'h108));
        check("sg_validd", ValidD, 1'b1);

        // Wraparound at the top of the address space
        gnt_dly = 0;
        rlat = 1;
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        FlushF = 1'b1;
        cyc();
        check("wr_flush", ValidD, 1'b0);
        PCSrcE = 1'b0;
        FlushF = 1'b0;
        mid();
        check("wr_addr_top", addr, 32'hFFFF_FFFC);
        cyc();
        mid();
        check("wr_addr_wrap", addr, 32'h0);
        cyc();
        check("wr_pcd", PCD, 32'hFFFF_FFFC);
        check("wr_pc4", PCPlus4D, 32'h0);
        check("wr_instr", InstrD, mem_word(32'hFFFF_FFFC));
        cyc();
        check("wr_pcd0", PCD, 32'h0);

        // Reset while a request is outstanding
        rlat = 4;
        cyc();
        check("rr_pre_pcd", PCD, 32'h4);
        rst_n = 1'b0;
        gnt_dly = 3;
        #1;
        check("rr_async_pcd", PCD, 32'h0);
        check("rr_async_valid", ValidD, 1'b0);
        check("rr_async_req", req, 1'b0);
        check("rr_async_addr", addr, 32'h0);
        repeat (2) cyc();
        rst_n = 1'b1;
        rlat = 1;
        cyc();
        check("rr_valid0", ValidD, 1'b0);
        mid();
        check("rr_req", req, 1'b1);
        check("rr_addr", addr, 32'h0);
        cyc();
        check("rr_late_ignored", ValidD, 1'b0);
        for (int i = 0; i < 8 && !ValidD; i++) cyc();
        check("rr_first_valid", ValidD, 1'b1);
        check("rr_first_pcd", PCD, 32'h0);
        check("rr_first_instr", InstrD, mem_word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
